// File: rtl/bcd_pulse_gen.sv
// -----------------------------------------------------------------------------
// bcd_pulse_gen
//   Calibrated pulse source: loads an N-digit BCD count and emits exactly that
//   many pulses inside a gate window, one pulse every PERIOD clock cycles. The
//   gate_o/pulse_out_o pair drives a gated BCD frequency counter, which then
//   reads back the loaded count.
//
// Ports
//   sclk_i       system clock, all logic on the rising edge
//   rst_i        synchronous reset, active-high
//   start_i      one-cycle request, sampled only in IDLE
//   stop_i       abort, sampled only in RUN
//   bcd_in_i     pulse count N (BCD, digit 0 in [3:0])
//   period_i     clock cycles per pulse P (0 behaves as 1)
//   gate_o       high for the whole generation window (N*P cycles)
//   pulse_out_o  high on the first cycle of every period while the gate is open
//   busy_o       high while generating
//   done_o       one-cycle strobe on normal completion
//   err_o        invalid BCD at start, sticky until the next accepted start
//   remaining_o  BCD count of pulses not yet emitted
// -----------------------------------------------------------------------------
module bcd_pulse_gen #(
  parameter int DIGITS = 8,
  parameter int DIV_W  = 16
) (
  input  logic                  sclk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [4*DIGITS-1:0]   bcd_in_i,
  input  logic [DIV_W-1:0]      period_i,
  output logic                  gate_o,
  output logic                  pulse_out_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [4*DIGITS-1:0]   remaining_o
);

  localparam int CW = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  period_m1_q;   // effective period minus one (P=0 folded to P=1)
  logic [DIV_W-1:0]  div_q;         // divider value of the cycle currently on the outputs
  logic [DIV_W-1:0]  div_d;
  logic [CW-1:0]     rem_q;
  logic [CW-1:0]     rem_dec_d;     // rem_q minus one, in BCD
  logic [CW-1:0]     load_dec_d;    // bcd_in_i minus one, in BCD (first pulse at load)
  logic [DIV_W-1:0]  load_pm1_d;
  logic              gate_q;
  logic              pulse_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // True when every nibble is a legal decimal digit.
  function automatic logic bcd_valid(input logic [CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Per-digit BCD decrement with borrow; a zero count is left at zero.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = (v != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // NOTE: every variable gets a value at the top of the block so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    div_d      = (div_q == period_m1_q) ? '0 : div_q + DIV_W'(1);
    rem_dec_d  = bcd_dec(rem_q);
    load_dec_d = bcd_dec(bcd_in_i);
    load_pm1_d = (period_i == '0) ? '0 : period_i - DIV_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      period_m1_q <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      gate_q      <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pulse_q <= 1'b0;
          if (start_i) begin
            err_q       <= 1'b0;
            period_m1_q <= load_pm1_d;
            div_q       <= '0;
            if (!bcd_valid(bcd_in_i)) begin
              err_q <= 1'b1;
              rem_q <= '0;
            end else if (bcd_in_i == '0) begin
              done_q <= 1'b1;
              rem_q  <= '0;
            end else begin
              // The first pulse is emitted on the very first gate cycle, so the
              // count already shows one pulse spent.
              state_q <= RUN;
              gate_q  <= 1'b1;
              busy_q  <= 1'b1;
              pulse_q <= 1'b1;
              rem_q   <= load_dec_d;
            end
          end
        end

        RUN: begin
          if (stop_i) begin
            // Abort wins over completion; remaining keeps the unsent count.
            state_q <= IDLE;
            gate_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            div_q <= div_d;
            if (div_d == '0) begin
              if (rem_q == '0) begin
                // Last period has completed: close the gate after exactly N*P cycles.
                state_q <= IDLE;
                gate_q  <= 1'b0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                pulse_q <= 1'b1;
                rem_q   <= rem_dec_d;
              end
            end else begin
              pulse_q <= 1'b0;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign gate_o      = gate_q;
  assign pulse_out_o = pulse_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign remaining_o = rem_q;

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_bcd_pulse_gen
//   Self-checking bench for bcd_pulse_gen. Each run is compared cycle by cycle
//   against a reference computed arithmetically from N, P and the stop/reset
//   cycle; a table of directed runs also carries summary expectations (pulse
//   count, done strobes, final err and remaining), followed by random runs.
// -----------------------------------------------------------------------------
module tb_bcd_pulse_gen;

  localparam int DIGITS = 8;
  localparam int DIV_W  = 16;
  localparam int CW     = 4 * DIGITS;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] bcd_in = '0;
  logic [DIV_W-1:0] period = '0;
  logic          gate, pulse, busy, done, err;
  logic [CW-1:0] remaining;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  bcd_pulse_gen #(.DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
    .sclk_i      (sclk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .bcd_in_i    (bcd_in),
    .period_i    (period),
    .gate_o      (gate),
    .pulse_out_o (pulse),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .remaining_o (remaining)
  );

  typedef struct {
    logic [CW-1:0]    bcd;
    logic [DIV_W-1:0] per;
    int               stop_at;     // cycle whose closing edge samples stop (0 = none)
    int               rst_at;      // cycle whose closing edge samples rst (0 = none)
    int               inject;      // cycle whose closing edge sees a spurious start (0 = none)
    int               exp_pulses;  // -1 skips the summary checks
    int               exp_done;
    int               exp_err;
    logic [CW-1:0]    exp_rem;
    string            name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic longint bcd2int(input logic [CW-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [CW-1:0] int2bcd(input longint n);
    logic [CW-1:0] r = '0;
    longint        x = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic is_valid(input logic [CW-1:0] v);
    logic ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Expected {gate, pulse, busy, done, err, remaining} in cycle c after the start edge.
  function automatic logic [36:0] expect_at(input logic [CW-1:0] bcd, input logic [DIV_W-1:0] per,
                                            input int stop_at, input int rst_at, input longint c);
    logic   g = 1'b0, p = 1'b0, b = 1'b0, d = 1'b0;
    longint n, pp, total, cc, rem = 0;
    if (rst_at > 0 && c > rst_at) return '0;
    if (!is_valid(bcd)) return {5'b00001, {CW{1'b0}}};
    n     = bcd2int(bcd);
    pp    = (per == '0) ? 1 : longint'(per);
    total = n * pp;
    cc    = (stop_at > 0 && c > stop_at) ? longint'(stop_at) : c;
    if (cc <= total) begin
      g   = 1'b1;
      b   = 1'b1;
      p   = ((cc - 1) % pp == 0);
      rem = n - ((cc - 1) / pp + 1);
    end else begin
      d = (cc == total + 1);
    end
    if (cc != c) begin
      g = 1'b0; p = 1'b0; b = 1'b0; d = 1'b0;
    end
    return {g, p, b, d, 1'b0, int2bcd(rem)};
  endfunction

  // ---------------- one generation run ----------------
  task automatic run_vec(input vec_t v);
    longint      n, pp, total, last;
    int          pulses = 0;
    int          dones = 0;
    logic [36:0] act_v, exp_v;
    n     = bcd2int(v.bcd);
    pp    = (v.per == '0) ? 1 : longint'(v.per);
    total = is_valid(v.bcd) ? n * pp : 0;
    if (v.rst_at > 0)       last = v.rst_at + 2;
    else if (v.stop_at > 0) last = v.stop_at + 2;
    else                    last = total + 2;

    @(negedge sclk);
    bcd_in = v.bcd;
    period = v.per;
    start  = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    for (longint c = 1; c <= last; c++) begin
      act_v = {gate, pulse, busy, done, err, remaining};
      exp_v = expect_at(v.bcd, v.per, v.stop_at, v.rst_at, c);
      check($sformatf("%s cycle %0d", v.name, c), 64'(act_v), 64'(exp_v));
      pulses += int'(pulse);
      dones  += int'(done);
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
      if (c == longint'(v.stop_at)) stop = 1'b1;
      if (c == longint'(v.rst_at))  rst  = 1'b1;
      if (c == longint'(v.inject)) begin
        start  = 1'b1;
        bcd_in = 32'h0000_0777;
        period = 16'd9;
      end
      @(negedge sclk);
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    if (v.exp_pulses >= 0) begin
      check({v.name, " pulses"},    64'(pulses),    64'(v.exp_pulses));
      check({v.name, " done"},      64'(dones),     64'(v.exp_done));
      check({v.name, " err"},       64'(err),       64'(v.exp_err));
      check({v.name, " remaining"}, 64'(remaining), 64'(v.exp_rem));
    end
  endtask

  vec_t tbl[12];

  initial begin
    vec_t   rv;
    longint n, pp, total;
    int     idx, sel;

    tbl[0]  = '{32'h0000_0003, 16'd4,      0, 0, 2,    3, 1, 0, 32'h0, "n3_p4"};
    tbl[1]  = '{32'h0000_1000, 16'd1,      0, 0, 0, 1000, 1, 0, 32'h0, "n1000_p1"};
    tbl[2]  = '{32'h0000_001A, 16'd4,      0, 0, 0,    0, 0, 1, 32'h0, "bad_digit"};
    tbl[3]  = '{32'h0000_0003, 16'd2,      0, 0, 0,    3, 1, 0, 32'h0, "clear_err"};
    tbl[4]  = '{32'h0000_0000, 16'd1,      0, 0, 0,    0, 1, 0, 32'h0, "zero_p1"};
    tbl[5]  = '{32'h0000_0000, 16'd0,      0, 0, 0,    0, 1, 0, 32'h0, "zero_p0"};
    tbl[6]  = '{32'h0000_0002, 16'd0,      0, 0, 0,    2, 1, 0, 32'h0, "n2_p0"};
    tbl[7]  = '{32'h0000_0002, 16'd1,      0, 0, 0,    2, 1, 0, 32'h0, "n2_p1"};
    tbl[8]  = '{32'h0000_0005, 16'd3,      4, 0, 2,    2, 0, 0, 32'h3, "stop_mid"};
    tbl[9]  = '{32'h0000_0002, 16'd2,      4, 0, 0,    2, 0, 0, 32'h0, "stop_last"};
    tbl[10] = '{32'h9999_9999, 16'hFFFF,   0, 3, 2,    1, 0, 0, 32'h0, "rst_mid"};
    tbl[11] = '{32'h0000_0003, 16'd4,      0, 0, 0,    3, 1, 0, 32'h0, "after_rst"};

    // Reset held with start asserted: reset must win and all outputs read zero.
    bcd_in = 32'h0000_0003;
    period = 16'd1;
    start  = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge sclk);
    check("reset state", 64'({gate, pulse, busy, done, err, remaining}), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    @(negedge sclk);
    check("idle after reset", 64'({gate, pulse, busy, done, err, remaining}), 64'(0));

    // Stop while idle is ignored.
    stop = 1'b1;
    @(negedge sclk);
    stop = 1'b0;
    check("stop in idle", 64'({gate, pulse, busy, done, err, remaining}), 64'(0));
    @(negedge sclk);
    check("idle after stop", 64'({gate, pulse, busy, done, err, remaining}), 64'(0));

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    for (int r = 0; r < 30; r++) begin
      n         = longint'($urandom_range(0, 60));
      rv.bcd    = int2bcd(n);
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, DIGITS - 1));
        rv.bcd[4*idx +: 4] = 4'($urandom_range(10, 15));
      end
      rv.per     = DIV_W'($urandom_range(0, 5));
      pp         = (rv.per == '0) ? 1 : longint'(rv.per);
      total      = is_valid(rv.bcd) ? bcd2int(rv.bcd) * pp : 0;
      rv.stop_at = 0;
      rv.rst_at  = 0;
      sel        = int'($urandom_range(0, 3));
      if (total > 0 && sel == 1) rv.stop_at = int'($urandom_range(1, int'(total)));
      if (total > 0 && sel == 2) rv.rst_at  = int'($urandom_range(1, int'(total)));
      rv.inject     = (total >= 2 && (rv.stop_at == 0 || rv.stop_at >= 2) &&
                       (rv.rst_at == 0 || rv.rst_at >= 2)) ? 2 : 0;
      rv.exp_pulses = -1;
      rv.exp_done   = 0;
      rv.exp_err    = 0;
      rv.exp_rem    = '0;
      rv.name       = $sformatf("rand%0d", r);
      run_vec(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
